mips_alu_mc: RTL and testbench
==============================

Name: mips_alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS ALU. It sits between the register-file read stage and write-back. Operands are accepted through a valid/ready handshake and results are returned through an output valid/ready handshake. On top of the existing AND/OR/ADD/SUB/SLT/NOR set it adds unsigned compare, shifts, signed-overflow detection, and iterative unsigned multiply/divide into internal HI/LO registers.

Parameters:
- WIDTH, 32, datapath width in bits. Power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- CLK  in  1  clock, rising-edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  operation presented.
- IN_READY  out  1  block can accept an operation. High only in IDLE.
- ALUCtl  in  4  operation code.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- SHAMT  in  SHW  shift amount.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes the result.
- ALUOut  out  WIDTH  result.
- Zero  out  1  ALUOut == 0.
- Overflow  out  1  signed overflow. ADD/SUB only, 0 otherwise.
- HI  out  WIDTH  HI register, continuously visible.
- LO  out  WIDTH  LO register, continuously visible.

Behaviour:
- ALUCtl encoding:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR. These are unchanged from the existing ALU.
  - 3 SLTU.
  - 4 SLL: B << SHAMT.
  - 5 SRL: B >> SHAMT, logical.
  - 8 SRA: B >>> SHAMT, arithmetic.
  - 9 MULTU.
  - 10 DIVU.
  - 11 MFHI: ALUOut = HI.
  - 13 MFLO: ALUOut = LO.
  - Any other code: ALUOut = 0, Zero = 1, single-cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept (IN_VALID & IN_READY) of a single-cycle op.
  - IDLE -> BUSY on accept of MULTU, or of DIVU with B != 0.
  - BUSY -> DONE after the last iteration.
  - DONE -> IDLE on OUT_READY.
  - An operation is never accepted in the same cycle as the DONE handshake, so maximum throughput is one single-cycle op per 2 clocks.
- Latency, with acceptance at rising edge k:
  - Single-cycle ops: result registered at edge k, OUT_VALID high from edge k.
  - MULTU / DIVU: one iteration per edge on edges k+1..k+WIDTH. OUT_VALID rises at edge k+WIDTH.
- Operand capture: A, B, SHAMT and ALUCtl are captured at accept. Input changes afterwards have no effect.
- MULTU: shift-add over WIDTH iterations. {HI,LO} = A*B, unsigned, 2*WIDTH bits. ALUOut = LO.
- DIVU: restoring division over WIDTH iterations. LO = A/B, HI = A%B, ALUOut = LO.
- DIVU with B = 0: no BUSY phase; goes IDLE -> DONE in one cycle. LO = all ones, HI = A, ALUOut = all ones.
- HI/LO update rule:
  - HI/LO change only at MULTU/DIVU completion.
  - During BUSY they keep their old values.
  - MFHI/MFLO return the values as of the accept edge.
- Overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - The result still wraps modulo 2^WIDTH.
- Hold: while OUT_VALID & !OUT_READY, ALUOut/Zero/Overflow stay stable. Zero/Overflow are registered together with ALUOut.
- Reset (RESET_N low, any time, including mid-BUSY):
  - State goes to IDLE and the iteration counter clears.
  - ALUOut = 0, Zero = 1, Overflow = 0, OUT_VALID = 0, HI = 0, LO = 0.
  - IN_READY = 1 while in reset.
  - Any in-flight operation is discarded.
- IN_VALID while not IDLE is ignored. The requester must hold it until IN_READY.

Test Plan:
1. WIDTH=32. ADD A=0x7FFFFFFF B=1 -> OUT_VALID at accept edge, ALUOut=0x80000000, Overflow=1, Zero=0. SUB A=5 B=5 -> ALUOut=0, Zero=1, Overflow=0.
2. SLT A=0xFFFFFFFF B=1 -> ALUOut=1. SLTU with the same operands -> ALUOut=0. NOR A=0 B=0 -> 0xFFFFFFFF.
3. SRA B=0x80000000 SHAMT=4 -> 0xF8000000. SRL with the same inputs -> 0x08000000. SLL B=1 SHAMT=31 -> 0x80000000.
4. MULTU A=0xFFFFFFFF B=2 -> IN_READY low for 32 cycles. OUT_VALID at accept+32 edges with HI=1, LO=0xFFFFFFFE, ALUOut=0xFFFFFFFE. A following MFHI returns 1.
5. DIVU A=100 B=7 -> LO=14, HI=2 after 32 cycles. DIVU A=5 B=0 -> OUT_VALID at the accept edge, LO=0xFFFFFFFF, HI=5.
6. Hold OUT_READY low for 3 cycles after an AND -> outputs stable, IN_READY low. Separately, pulse RESET_N low at cycle 10 of a MULTU -> OUT_VALID=0, IN_READY=1, HI=LO=0; a new ADD then completes normally.

Source files
------------

// File: rtl/mips_alu_mc.sv
// mips_alu_mc -- multi-cycle MIPS ALU with valid/ready handshakes.
//
// Sits between register-file read and write-back. One operation is accepted
// in IDLE, its result is held in DONE until the consumer takes it. Logic and
// arithmetic ops finish at the accept edge; MULTU (shift-add) and DIVU
// (restoring) iterate once per clock for WIDTH clocks into HI/LO.
//
// Ports:
//   CLK, RESET_N          rising-edge clock, asynchronous active-low reset
//   IN_VALID / IN_READY   operation handshake (IN_READY high only in IDLE)
//   ALUCtl, A, B, SHAMT   operation code, rs, rt, shift amount
//   OUT_VALID / OUT_READY result handshake
//   ALUOut, Zero, Overflow registered result and flags
//   HI, LO                multiply/divide result registers
module mips_alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   SHAMT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // acc: running high product / partial remainder.
  // mq:  multiplier shifting out / dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] acc_next, mq_next;

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign ALUOut    = out_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

  // Single-cycle result, computed straight from the live inputs so it can be
  // registered on the accept edge.
  always_comb begin
    sum    = A + B;
    diff   = A - B;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUCtl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  sc_res = ~(A | B);
      OP_SLL:  sc_res = B << SHAMT;
      OP_SRL:  sc_res = B >> SHAMT;
      OP_SRA:  sc_res = $signed(B) >>> SHAMT;
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  // One iteration of the shared multiply/divide engine.
  // Multiply: add the multiplicand into the high half when the multiplier
  // LSB is set, then shift the whole {carry,acc,mq} right by one.
  // Divide: shift {acc,mq} left by one and subtract the divisor when it fits;
  // the partial remainder is always below the divisor, so WIDTH+1 bits hold
  // the shifted value and the difference fits back into WIDTH bits.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, mq_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_sub  = div_sh[WIDTH-1:0] - opnd_q;
    acc_next = mul_sum[WIDTH:1];
    mq_next  = {mul_sum[0], mq_q[WIDTH-1:1]};
    if (is_div_q) begin
      acc_next = div_ge ? div_sub : div_sh[WIDTH-1:0];
      mq_next  = {mq_q[WIDTH-2:0], div_ge};
    end
  end

  // Next-state and register updates. HI/LO only move when a multiply or
  // divide completes (or a divide by zero is accepted).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    out_d    = out_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          cnt_d = '0;
          if (ALUCtl == OP_MULTU) begin
            is_div_d = 1'b0;
            opnd_d   = A;
            acc_d    = '0;
            mq_d     = B;
            state_d  = BUSY;
          end else if ((ALUCtl == OP_DIVU) && (B != '0)) begin
            is_div_d = 1'b1;
            opnd_d   = B;
            acc_d    = '0;
            mq_d     = A;
            state_d  = BUSY;
          end else if (ALUCtl == OP_DIVU) begin
            hi_d    = A;
            lo_d    = '1;
            out_d   = '1;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            out_d   = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = acc_next;
        mq_d  = mq_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          cnt_d   = '0;
          hi_d    = acc_next;
          lo_d    = mq_next;
          out_d   = mq_next;
          zero_d  = (mq_next == '0);
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_alu_mc.sv
// tb_mips_alu_mc -- table-driven self-checking bench for mips_alu_mc (WIDTH=32).
module tb_mips_alu_mc;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [3:0]  ALUCtl = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [4:0]  SHAMT = 5'd0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] ALUOut;
  logic        Zero;
  logic        Overflow;
  logic [31:0] HI;
  logic [31:0] LO;

  int compared = 0;
  int mismatched = 0;
  int lastLat = 0;
  int readyInBusy = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] expOut;
    logic        expZero;
    logic        expOvf;
    int          expLat;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[21];

  mips_alu_mc #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALUCtl(ALUCtl), .A(A), .B(B), .SHAMT(SHAMT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow),
    .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mkVec(string name, logic [3:0] op, logic [31:0] a,
                                 logic [31:0] b, logic [4:0] sh, logic [31:0] expOut,
                                 logic expZero, logic expOvf, int expLat,
                                 logic [31:0] expHi, logic [31:0] expLo);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.expOut = expOut; v.expZero = expZero; v.expOvf = expOvf;
    v.expLat = expLat; v.expHi = expHi; v.expLo = expLo;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present an op, wait for its accept edge, scramble the inputs, then wait
  // (bounded) for OUT_VALID. lastLat = edges after the accept edge.
  task automatic applyStimulus(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    int guard;
    ALUCtl = op; A = a; B = b; SHAMT = sh; IN_VALID = 1'b1;
    guard = 0;
    while (!IN_READY && guard < 100) begin
      @(posedge CLK); #1; guard++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A = $urandom; B = $urandom; SHAMT = 5'($urandom); ALUCtl = 4'd2;
    lastLat = 0;
    readyInBusy = 0;
    while (!OUT_VALID && lastLat < 100) begin
      if (IN_READY) readyInBusy++;
      @(posedge CLK); #1;
      lastLat++;
    end
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  initial begin
    int quietCycles;
    vecs[0]  = mkVec("add_ovf",  4'd2,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b1, 0,  32'h0, 32'h0);
    vecs[1]  = mkVec("sub_zero", 4'd6,  32'd5,        32'd5,        5'd0,  32'h0,        1'b1, 1'b0, 0,  32'h0, 32'h0);
    vecs[2]  = mkVec("slt",      4'd7,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[3]  = mkVec("sltu",     4'd3,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0, 0,  32'h0, 32'h0);
    vecs[4]  = mkVec("nor",      4'd12, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[5]  = mkVec("sra",      4'd8,  32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[6]  = mkVec("srl",      4'd5,  32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[7]  = mkVec("sll",      4'd4,  32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[8]  = mkVec("and",      4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[9]  = mkVec("or",       4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0, 0,  32'h0, 32'h0);
    vecs[10] = mkVec("sub_ovf",  4'd6,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 0,  32'h0, 32'h0);
    vecs[11] = mkVec("multu",    4'd9,  32'hFFFFFFFF, 32'h2,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 32, 32'h1, 32'hFFFFFFFE);
    vecs[12] = mkVec("mfhi",     4'd11, 32'h0,        32'h0,        5'd0,  32'h1,        1'b0, 1'b0, 0,  32'h1, 32'hFFFFFFFE);
    vecs[13] = mkVec("mflo",     4'd13, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 0,  32'h1, 32'hFFFFFFFE);
    vecs[14] = mkVec("divu",     4'd10, 32'd100,      32'd7,        5'd0,  32'd14,       1'b0, 1'b0, 32, 32'd2, 32'd14);
    vecs[15] = mkVec("divu_z",   4'd10, 32'd5,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 0,  32'd5, 32'hFFFFFFFF);
    vecs[16] = mkVec("mfhi_dz",  4'd11, 32'h0,        32'h0,        5'd0,  32'd5,        1'b0, 1'b0, 0,  32'd5, 32'hFFFFFFFF);
    vecs[17] = mkVec("undef",    4'd14, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h0,        1'b1, 1'b0, 0,  32'd5, 32'hFFFFFFFF);
    vecs[18] = mkVec("multu_hi", 4'd9,  32'h00010000, 32'h00010000, 5'd0,  32'h0,        1'b1, 1'b0, 32, 32'h1, 32'h0);
    vecs[19] = mkVec("divu_big", 4'd10, 32'hFFFFFFFF, 32'h10,       5'd0,  32'h0FFFFFFF, 1'b0, 1'b0, 32, 32'hF, 32'h0FFFFFFF);
    vecs[20] = mkVec("add_wrap", 4'd2,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0, 0,  32'hF, 32'h0FFFFFFF);

    // Reset state, checked while reset is still asserted.
    #12;
    checkOutput("rst_in_ready",  64'(IN_READY),  64'd1);
    checkOutput("rst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("rst_aluout",    64'(ALUOut),    64'd0);
    checkOutput("rst_zero",      64'(Zero),      64'd1);
    checkOutput("rst_ovf",       64'(Overflow),  64'd0);
    checkOutput("rst_hi",        64'(HI),        64'd0);
    checkOutput("rst_lo",        64'(LO),        64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      checkOutput({vecs[i].name, "_lat"},  64'(lastLat),   64'(vecs[i].expLat));
      checkOutput({vecs[i].name, "_out"},  64'(ALUOut),    64'(vecs[i].expOut));
      checkOutput({vecs[i].name, "_zero"}, 64'(Zero),      64'(vecs[i].expZero));
      checkOutput({vecs[i].name, "_ovf"},  64'(Overflow),  64'(vecs[i].expOvf));
      checkOutput({vecs[i].name, "_hi"},   64'(HI),        64'(vecs[i].expHi));
      checkOutput({vecs[i].name, "_lo"},   64'(LO),        64'(vecs[i].expLo));
      if (vecs[i].expLat > 0)
        checkOutput({vecs[i].name, "_busy_ready"}, 64'(readyInBusy), 64'd0);
      consume();
    end

    // Stall the consumer for 3 cycles; a competing request must be ignored.
    applyStimulus(4'd0, 32'h00000F0F, 32'h000000FF, 5'd0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ALUCtl = 4'd2; A = 32'd1; B = 32'd1; IN_VALID = 1'b1;
      end
      checkOutput("hold_valid", 64'(OUT_VALID), 64'd1);
      checkOutput("hold_ready", 64'(IN_READY),  64'd0);
      checkOutput("hold_out",   64'(ALUOut),    64'h0000000F);
      checkOutput("hold_zero",  64'(Zero),      64'd0);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    consume();
    checkOutput("hold_after_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("hold_after_ready", 64'(IN_READY),  64'd1);

    // Reset in the middle of a MULTU: HI/LO hold old values until reset clears them.
    ALUCtl = 4'd9; A = 32'h12345678; B = 32'h9ABCDEF0; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (9) begin
      @(posedge CLK); #1;
    end
    checkOutput("mid_busy_ready", 64'(IN_READY), 64'd0);
    checkOutput("mid_busy_hi",    64'(HI),       64'h0000000F);
    checkOutput("mid_busy_lo",    64'(LO),       64'h0FFFFFFF);
    RESET_N = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("mid_rst_ready", 64'(IN_READY),  64'd1);
    checkOutput("mid_rst_hi",    64'(HI),        64'd0);
    checkOutput("mid_rst_lo",    64'(LO),        64'd0);
    checkOutput("mid_rst_zero",  64'(Zero),      64'd1);
    @(negedge CLK);
    RESET_N = 1'b1;
    quietCycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) quietCycles++;
    end
    checkOutput("mid_rst_discard", 64'(quietCycles), 64'd0);
    applyStimulus(4'd2, 32'd2, 32'd3, 5'd0);
    checkOutput("post_rst_lat", 64'(lastLat), 64'd0);
    checkOutput("post_rst_out", 64'(ALUOut),  64'd5);
    checkOutput("post_rst_hi",  64'(HI),      64'd0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
